// File: rtl/plab5_mcore_part_mem_pkg.sv
// rtl/plab5_mcore_part_mem_pkg.sv - vc-mem message encodings, field layout helpers, owner FSM states
package plab5_mcore_part_mem_pkg;

    localparam int MSG_TYPE_NBITS = 3;

    typedef enum logic [MSG_TYPE_NBITS-1:0] {
        MEM_READ       = 3'd0,
        MEM_WRITE      = 3'd1,
        MEM_WRITE_INIT = 3'd2,
        MEM_AMO_ADD    = 3'd3,
        MEM_AMO_AND    = 3'd4,
        MEM_AMO_OR     = 3'd5
    } mem_type_e;

    typedef enum logic {
        OWN_IDLE  = 1'b0,
        OWN_SCRUB = 1'b1
    } owner_state_e;

    // Request layout {type, opaque, addr, len, data}; response layout {type, opaque, len, data}
    function automatic int mem_len_nbits(input int d);
        return $clog2(d / 8);
    endfunction

    function automatic int req_addr_lsb(input int d);
        return d + mem_len_nbits(d);
    endfunction

    function automatic int req_opaque_lsb(input int a, input int d);
        return req_addr_lsb(d) + a;
    endfunction

    function automatic int req_type_lsb(input int o, input int a, input int d);
        return req_opaque_lsb(a, d) + o;
    endfunction

    function automatic int vc_mem_req_msg_nbits(input int o, input int a, input int d);
        return req_type_lsb(o, a, d) + MSG_TYPE_NBITS;
    endfunction

    function automatic int resp_opaque_lsb(input int d);
        return d + mem_len_nbits(d);
    endfunction

    function automatic int resp_type_lsb(input int o, input int d);
        return resp_opaque_lsb(d) + o;
    endfunction

    function automatic int vc_mem_resp_msg_nbits(input int o, input int d);
        return resp_type_lsb(o, d) + MSG_TYPE_NBITS;
    endfunction

endpackage

// File: rtl/plab5_mcore_part_mem_owner_ctrl.sv
// rtl/plab5_mcore_part_mem_owner_ctrl.sv - partition owner table; scrub FSM when PLAB5_MCORE_PART_MEM_SCRUB_EN is defined
module plab5_mcore_part_mem_owner_ctrl
    import plab5_mcore_part_mem_pkg::*;
#(
    parameter int p_num_parts      = 4,
    parameter int p_dom_nbits      = 1,
    parameter int p_words_per_part = 256,
    localparam int c_part_nbits    = $clog2(p_num_parts),
    localparam int c_cnt_nbits     = $clog2(p_words_per_part)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 i_cfg_val,
    output logic                                 o_cfg_rdy,
    input  logic [c_part_nbits-1:0]              i_cfg_part,
    input  logic [p_dom_nbits-1:0]               i_cfg_owner,
    input  logic [c_part_nbits-1:0]              i_rd_part,
    output logic [p_dom_nbits-1:0]               o_rd_owner,
    output logic                                 o_busy,
    output logic                                 o_scrub_wen,
    output logic [c_part_nbits+c_cnt_nbits-1:0]  o_scrub_widx
);

    logic [p_dom_nbits-1:0] r_owner [p_num_parts];
    logic                   r_up;
    logic                   w_cfg_fire;

    assign o_rd_owner = r_owner[i_rd_part];
    assign w_cfg_fire = i_cfg_val && o_cfg_rdy;

    always_ff @(posedge clk) begin
        r_up <= !reset;
        if (reset) begin
            for (int i = 0; i < p_num_parts; i++)
                r_owner[i] <= p_dom_nbits'(i);
        end else if (w_cfg_fire) begin
            r_owner[i_cfg_part] <= i_cfg_owner;
        end
    end

`ifdef PLAB5_MCORE_PART_MEM_SCRUB_EN
    owner_state_e            r_state;
    owner_state_e            w_state_nx;
    logic [c_part_nbits-1:0] r_part;
    logic [c_cnt_nbits-1:0]  r_cnt;

    assign o_cfg_rdy    = r_up && !reset && (r_state == OWN_IDLE);
    assign o_scrub_widx = {r_part, r_cnt};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= OWN_IDLE;
            r_part  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_cfg_fire) begin
                r_part <= i_cfg_part;
                r_cnt  <= '0;
            end else if (r_state == OWN_SCRUB) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Only a real ownership change clears the partition; one word per cycle
    always_comb begin
        w_state_nx  = r_state;
        o_busy      = 1'b0;
        o_scrub_wen = 1'b0;
        case (r_state)
            OWN_IDLE: begin
                if (w_cfg_fire && (i_cfg_owner != r_owner[i_cfg_part]))
                    w_state_nx = OWN_SCRUB;
            end
            OWN_SCRUB: begin
                o_busy      = 1'b1;
                o_scrub_wen = 1'b1;
                if (r_cnt == {c_cnt_nbits{1'b1}})
                    w_state_nx = OWN_IDLE;
            end
            default: w_state_nx = OWN_IDLE;
        endcase
    end
`else
    assign o_cfg_rdy    = r_up && !reset;
    assign o_busy       = 1'b0;
    assign o_scrub_wen  = 1'b0;
    assign o_scrub_widx = '0;
`endif

endmodule

// File: rtl/plab5_mcore_part_mem.sv
// rtl/plab5_mcore_part_mem.sv - partitioned memory with per-domain ownership checks
// Optional partition scrub on ownership change: PLAB5_MCORE_PART_MEM_SCRUB_EN
module plab5_mcore_part_mem
    import plab5_mcore_part_mem_pkg::*;
#(
    parameter int p_mem_nbytes   = 4096,
    parameter int p_num_parts    = 4,
    parameter int p_dom_nbits    = 1,
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 32,
    localparam int c_req_nbits   = vc_mem_req_msg_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits),
    localparam int c_resp_nbits  = vc_mem_resp_msg_nbits(p_opaque_nbits, p_data_nbits),
    localparam int c_part_nbits  = $clog2(p_num_parts)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      memreq_val,
    output logic                      memreq_rdy,
    input  logic [c_req_nbits-1:0]    memreq_msg,
    input  logic [p_dom_nbits-1:0]    memreq_domain,
    output logic                      memresp_val,
    input  logic                      memresp_rdy,
    output logic [c_resp_nbits-1:0]   memresp_msg,
    output logic [p_dom_nbits-1:0]    memresp_domain,
    output logic                      memresp_err,
    input  logic                      cfg_val,
    output logic                      cfg_rdy,
    input  logic [c_part_nbits-1:0]   cfg_part,
    input  logic [p_dom_nbits-1:0]    cfg_owner,
    output logic [15:0]               deny_count
);

    localparam int c_len_nbits  = mem_len_nbits(p_data_nbits);
    localparam int c_nbytes_w   = p_data_nbits / 8;
    localparam int c_mem_abits  = $clog2(p_mem_nbytes);
    localparam int c_nwords     = p_mem_nbytes / c_nbytes_w;
    localparam int c_widx_nbits = c_mem_abits - c_len_nbits;
    localparam int c_addr_lsb   = req_addr_lsb(p_data_nbits);
    localparam int c_opq_lsb    = req_opaque_lsb(p_addr_nbits, p_data_nbits);
    localparam int c_type_lsb   = req_type_lsb(p_opaque_nbits, p_addr_nbits, p_data_nbits);

    logic [p_data_nbits-1:0]   r_mem [c_nwords];

    logic                      r_up;
    logic                      r_m_val;
    logic [c_req_nbits-1:0]    r_m_msg;
    logic [p_dom_nbits-1:0]    r_m_dom;
    logic                      r_o_full;
    logic [c_resp_nbits-1:0]   r_o_msg;
    logic [p_dom_nbits-1:0]    r_o_dom;
    logic                      r_o_err;
    logic [15:0]               r_deny_count;

    logic [MSG_TYPE_NBITS-1:0] w_m_type;
    logic [p_opaque_nbits-1:0] w_m_opq;
    logic [c_len_nbits-1:0]    w_m_len;
    logic [c_len_nbits-1:0]    w_m_off;
    logic [c_len_nbits:0]      w_m_nbytes;
    logic [c_nbytes_w-1:0]     w_m_bmask;
    logic [p_data_nbits-1:0]   w_m_data;
    logic [p_data_nbits-1:0]   w_m_word;
    logic [p_data_nbits-1:0]   w_m_rdata;
    logic [p_data_nbits-1:0]   w_m_newv;
    logic [p_data_nbits-1:0]   w_m_wword;
    logic [p_data_nbits-1:0]   w_m_merged;
    logic [c_part_nbits-1:0]   w_m_part;
    logic [c_widx_nbits-1:0]   w_m_widx;
    logic [c_widx_nbits-1:0]   w_scrub_widx;
    logic [p_dom_nbits-1:0]    w_owner;
    logic [c_resp_nbits-1:0]   w_m_resp;
    logic                      w_m_allow;
    logic                      w_m_fire;
    logic                      w_m_is_wr;
    logic                      w_busy;
    logic                      w_scrub_wen;
    logic                      w_unused_addr;

    assign w_m_type  = r_m_msg[c_type_lsb +: MSG_TYPE_NBITS];
    assign w_m_opq   = r_m_msg[c_opq_lsb +: p_opaque_nbits];
    assign w_m_len   = r_m_msg[p_data_nbits +: c_len_nbits];
    assign w_m_data  = r_m_msg[0 +: p_data_nbits];
    assign w_m_off   = r_m_msg[c_addr_lsb +: c_len_nbits];
    assign w_m_widx  = r_m_msg[c_addr_lsb + c_len_nbits +: c_widx_nbits];
    assign w_m_part  = r_m_msg[c_addr_lsb + c_mem_abits - c_part_nbits +: c_part_nbits];
    assign w_unused_addr = ^r_m_msg[c_addr_lsb + c_mem_abits +: (p_addr_nbits - c_mem_abits)];

    plab5_mcore_part_mem_owner_ctrl #(
        .p_num_parts      (p_num_parts),
        .p_dom_nbits      (p_dom_nbits),
        .p_words_per_part (c_nwords / p_num_parts)
    ) u_owner_ctrl (
        .clk          (clk),
        .reset        (reset),
        .i_cfg_val    (cfg_val),
        .o_cfg_rdy    (cfg_rdy),
        .i_cfg_part   (cfg_part),
        .i_cfg_owner  (cfg_owner),
        .i_rd_part    (w_m_part),
        .o_rd_owner   (w_owner),
        .o_busy       (w_busy),
        .o_scrub_wen  (w_scrub_wen),
        .o_scrub_widx (w_scrub_widx)
    );

    // Owner table read sees the pre-update value when a cfg lands in the same cycle
    assign w_m_allow = (w_owner == r_m_dom);
    assign w_m_fire  = r_m_val && !r_o_full;
    assign w_m_word  = r_mem[w_m_widx];
    assign w_m_rdata = w_m_word >> {w_m_off, 3'b000};

    always_comb begin
        w_m_nbytes = (w_m_len == '0) ? (c_len_nbits + 1)'(c_nbytes_w) : {1'b0, w_m_len};
        for (int b = 0; b < c_nbytes_w; b++)
            w_m_bmask[b] = (b >= int'(w_m_off)) && (b < int'(w_m_off) + int'(w_m_nbytes));
        w_m_is_wr = 1'b1;
        w_m_newv  = w_m_data;
        case (w_m_type)
            MEM_WRITE, MEM_WRITE_INIT: w_m_newv = w_m_data;
            MEM_AMO_ADD:               w_m_newv = w_m_rdata + w_m_data;
            MEM_AMO_AND:               w_m_newv = w_m_rdata & w_m_data;
            MEM_AMO_OR:                w_m_newv = w_m_rdata | w_m_data;
            default:                   w_m_is_wr = 1'b0;
        endcase
        w_m_wword = w_m_newv << {w_m_off, 3'b000};
        for (int b = 0; b < c_nbytes_w; b++)
            w_m_merged[b*8 +: 8] = w_m_bmask[b] ? w_m_wword[b*8 +: 8] : w_m_word[b*8 +: 8];
    end

    assign w_m_resp = {w_m_type, w_m_opq, w_m_len,
                       (w_m_allow ? w_m_rdata : {p_data_nbits{1'b0}})};

    // Output bypass queue: M result goes straight out unless a response is already parked
    assign memresp_val    = !reset && (r_o_full || r_m_val);
    assign memresp_msg    = r_o_full ? r_o_msg : w_m_resp;
    assign memresp_domain = r_o_full ? r_o_dom : r_m_dom;
    assign memresp_err    = !reset && (r_o_full ? r_o_err : (r_m_val && !w_m_allow));
    assign memreq_rdy     = r_up && !reset && !w_busy && (!r_m_val || w_m_fire);
    assign deny_count     = r_deny_count;

    always_ff @(posedge clk) begin
        if (!reset && w_m_fire && w_m_allow && w_m_is_wr)
            r_mem[w_m_widx] <= w_m_merged;
        if (w_scrub_wen)
            r_mem[w_scrub_widx] <= '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_up         <= 1'b0;
            r_m_val      <= 1'b0;
            r_o_full     <= 1'b0;
            r_deny_count <= 16'd0;
        end else begin
            r_up <= 1'b1;
            if (memreq_val && memreq_rdy) begin
                r_m_val <= 1'b1;
                r_m_msg <= memreq_msg;
                r_m_dom <= memreq_domain;
            end else if (w_m_fire) begin
                r_m_val <= 1'b0;
            end
            if (w_m_fire && !memresp_rdy) begin
                r_o_full <= 1'b1;
                r_o_msg  <= w_m_resp;
                r_o_dom  <= r_m_dom;
                r_o_err  <= !w_m_allow;
            end else if (r_o_full && memresp_rdy) begin
                r_o_full <= 1'b0;
            end
            if (w_m_fire && !w_m_allow && (r_deny_count != 16'hFFFF))
                r_deny_count <= r_deny_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_plab5_mcore_part_mem.sv
// tb/tb_plab5_mcore_part_mem.sv - randomized self-checking bench against a byte-level memory model
module tb_plab5_mcore_part_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        memreq_val, memreq_rdy;
    logic [76:0] memreq_msg;
    logic [0:0]  memreq_domain;
    logic        memresp_val, memresp_rdy;
    logic [44:0] memresp_msg;
    logic [0:0]  memresp_domain;
    logic        memresp_err;
    logic        cfg_val, cfg_rdy;
    logic [1:0]  cfg_part;
    logic [0:0]  cfg_owner;
    logic [15:0] deny_count;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] m_mem [4096];
    logic       m_own [4];
    int         m_deny;

    always #5 clk = ~clk;

    plab5_mcore_part_mem dut (
        .clk            (clk),
        .reset          (reset),
        .memreq_val     (memreq_val),
        .memreq_rdy     (memreq_rdy),
        .memreq_msg     (memreq_msg),
        .memreq_domain  (memreq_domain),
        .memresp_val    (memresp_val),
        .memresp_rdy    (memresp_rdy),
        .memresp_msg    (memresp_msg),
        .memresp_domain (memresp_domain),
        .memresp_err    (memresp_err),
        .cfg_val        (cfg_val),
        .cfg_rdy        (cfg_rdy),
        .cfg_part       (cfg_part),
        .cfg_owner      (cfg_owner),
        .deny_count     (deny_count)
    );

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_own[i] = i[0];
        m_deny = 0;
    endfunction

    // Byte-addressed model: partition = byte address / 1024, little-endian words of 4 bytes
    function automatic void model_access(input int t, input logic [31:0] addr, input int len,
                                         input logic [31:0] data, input logic dom,
                                         output logic [31:0] exp_data, output logic exp_err);
        int a, base, off, nb;
        logic [31:0] old, nv;
        a    = int'(addr[11:0]);
        base = a - (a % 4);
        off  = a % 4;
        nb   = (len == 0) ? 4 : len;
        if (m_own[a / 1024] != dom) begin
            exp_err  = 1'b1;
            exp_data = 32'd0;
            if (m_deny < 65535) m_deny++;
            return;
        end
        exp_err = 1'b0;
        old = 32'd0;
        for (int b = off; b < 4; b++) old = old | (32'(m_mem[base + b]) << (8 * (b - off)));
        exp_data = old;
        case (t)
            1, 2:    nv = data;
            3:       nv = old + data;
            4:       nv = old & data;
            5:       nv = old | data;
            default: return;
        endcase
        for (int k = 0; k < nb && off + k < 4; k++) m_mem[base + off + k] = nv[8*k +: 8];
    endfunction

    task automatic do_req(input logic [76:0] msg, input logic dom, output logic [44:0] rmsg,
                          output logic rdom, output logic rerr, output int lat);
        int n;
        n = 0;
        memreq_msg = msg; memreq_domain = dom; memreq_val = 1'b1; memresp_rdy = 1'b1;
        while (memreq_rdy !== 1'b1 && n < 1000) begin @(posedge clk); #1; n++; end
        if (n >= 1000) begin
            n_cmp++; n_fail++;
            $display("FAIL req_accept_timeout: memreq_rdy=%b required 1", memreq_rdy);
        end
        @(posedge clk); #1;
        memreq_val = 1'b0;
        lat = 0;
        while (memresp_val !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
        rmsg = memresp_msg; rdom = memresp_domain; rerr = memresp_err;
        @(posedge clk); #1;
    endtask

    task automatic xact(input int t, input logic [31:0] addr, input int len, input logic [31:0] data,
                        input logic dom, output logic [44:0] exp_msg, output logic exp_err,
                        output logic [44:0] rmsg, output logic rdom, output logic rerr, output int lat);
        logic [7:0]  opq;
        logic [31:0] ed;
        opq = 8'($urandom);
        model_access(t, addr, len, data, dom, ed, exp_err);
        exp_msg = {3'(t), opq, 2'(len), ed};
        do_req({3'(t), opq, addr, 2'(len), data}, dom, rmsg, rdom, rerr, lat);
    endtask

    task automatic do_cfg(input logic [1:0] part, input logic owner);
        int n;
        n = 0;
        cfg_part = part; cfg_owner = owner; cfg_val = 1'b1;
        while (cfg_rdy !== 1'b1 && n < 1000) begin @(posedge clk); #1; n++; end
        n_cmp++;
        if (n >= 1000) begin
            n_fail++;
            $display("FAIL cfg_accept_timeout: cfg_rdy=%b required 1", cfg_rdy);
        end
        @(posedge clk); #1;
        cfg_val = 1'b0;
        m_own[part] = owner;
    endtask

    task automatic test_reset();
        reset = 1'b1; memreq_val = 1'b0; memreq_msg = '0; memreq_domain = '0;
        memresp_rdy = 1'b1; cfg_val = 1'b0; cfg_part = '0; cfg_owner = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({memreq_rdy, memresp_val, memresp_err, cfg_rdy, deny_count} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_state: rdy/val/err/cfg_rdy/deny=%h required 0",
                     {memreq_rdy, memresp_val, memresp_err, cfg_rdy, deny_count});
        end
        reset = 1'b0;
        n_cmp++;
        if (memreq_rdy !== 1'b0) begin
            n_fail++; $display("FAIL rdy_before_first_cycle: got %b required 0", memreq_rdy);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (memreq_rdy !== 1'b1 || cfg_rdy !== 1'b1) begin
            n_fail++; $display("FAIL rdy_after_reset: memreq_rdy=%b cfg_rdy=%b required 1 1", memreq_rdy, cfg_rdy);
        end
        model_reset();
    endtask

    task automatic test_init();
        logic [44:0] em, rm; logic ee, rd, re; int lat, bad;
        bad = 0;
        for (int w = 0; w < 1024; w++) begin
            xact(2, 32'(w * 4), 0, $urandom, m_own[w / 256], em, ee, rm, rd, re, lat);
            if (re !== 1'b0 || rm !== em) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_fail++; $display("FAIL init_writes: %0d bad responses required 0", bad); end
    endtask

    task automatic test_directed();
        logic [44:0] em, rm; logic ee, rd, re; int lat;
        xact(1, 32'h010, 0, 32'hDEADBEEF, 1'b0, em, ee, rm, rd, re, lat);
        xact(0, 32'h010, 0, 32'h0, 1'b0, em, ee, rm, rd, re, lat);
        n_cmp++;
        if (rm[31:0] !== 32'hDEADBEEF || re !== 1'b0 || lat != 0 || rm !== em) begin
            n_fail++; $display("FAIL read_after_write: data=%h err=%b lat=%0d required deadbeef 0 0", rm[31:0], re, lat);
        end
        xact(1, 32'h410, 0, 32'h12345678, 1'b0, em, ee, rm, rd, re, lat);
        n_cmp++;
        if (re !== 1'b1 || rm[31:0] !== 32'h0 || deny_count !== 16'd1) begin
            n_fail++; $display("FAIL denied_write: err=%b data=%h deny=%0d required 1 0 1", re, rm[31:0], deny_count);
        end
        xact(0, 32'h410, 0, 32'h0, 1'b1, em, ee, rm, rd, re, lat);
        n_cmp++;
        if (re !== 1'b0 || rm[31:0] === 32'h12345678 || rm !== em) begin
            n_fail++; $display("FAIL denied_write_effect: data=%h err=%b required %h 0", rm[31:0], re, em[31:0]);
        end
        xact(1, 32'h400, 0, 32'd10, 1'b1, em, ee, rm, rd, re, lat);
        xact(3, 32'h400, 0, 32'd5, 1'b1, em, ee, rm, rd, re, lat);
        n_cmp++;
        if (rm[31:0] !== 32'd10 || re !== 1'b0 || rm[44:42] !== 3'd3) begin
            n_fail++; $display("FAIL amo_add_old: data=%0d type=%0d required 10 3", rm[31:0], rm[44:42]);
        end
        xact(0, 32'h400, 0, 32'h0, 1'b1, em, ee, rm, rd, re, lat);
        n_cmp++;
        if (rm[31:0] !== 32'd15) begin
            n_fail++; $display("FAIL amo_add_new: data=%0d required 15", rm[31:0]);
        end
        xact(1, 32'h013, 1, 32'h000000AB, 1'b0, em, ee, rm, rd, re, lat);
        xact(0, 32'h010, 0, 32'h0, 1'b0, em, ee, rm, rd, re, lat);
        n_cmp++;
        if (rm[31:0] !== 32'hABADBEEF) begin
            n_fail++; $display("FAIL byte_write: data=%h required abadbeef", rm[31:0]);
        end
    endtask

    task automatic test_random();
        logic [44:0] em, rm; logic ee, rd, re; int lat; logic dom;
        for (int i = 0; i < 300; i++) begin
            dom = 1'($urandom);
            xact($urandom_range(0, 5), $urandom, $urandom_range(0, 3), $urandom, dom, em, ee, rm, rd, re, lat);
            n_cmp++;
            if (rm !== em || re !== ee || rd !== dom || lat != 0) begin
                n_fail++;
                $display("FAIL random_%0d: msg=%h err=%b dom=%b lat=%0d required %h %b %b 0",
                         i, rm, re, rd, lat, em, ee, dom);
            end
        end
        n_cmp++;
        if (deny_count !== 16'(m_deny)) begin
            n_fail++; $display("FAIL deny_count: got %0d required %0d", deny_count, m_deny);
        end
    endtask

    task automatic test_back_to_back();
        logic [76:0] msgs [8]; logic doms [8]; logic [44:0] expq [8];
        logic [31:0] ed, a; logic ee, acc, rcv;
        int sent, got, cyc, outst;
        for (int i = 0; i < 8; i++) begin
            a = 32'($urandom_range(0, 1023) * 4);
            doms[i] = m_own[a[11:10]];
            msgs[i] = {3'd0, 8'(i), a, 2'd0, 32'd0};
            model_access(0, a, 0, 32'd0, doms[i], ed, ee);
            expq[i] = {3'd0, 8'(i), 2'd0, ed};
        end
        sent = 0; got = 0; cyc = 0; outst = 0;
        while (got < 8 && cyc < 100) begin
            memreq_val = (sent < 8);
            if (sent < 8) begin memreq_msg = msgs[sent]; memreq_domain = doms[sent]; end
            memresp_rdy = (cyc % 2 == 0);
            #1;
            n_cmp++;
            if (memreq_rdy !== (outst < 2)) begin
                n_fail++; $display("FAIL b2b_rdy_cyc%0d: got %b required %b", cyc, memreq_rdy, outst < 2);
            end
            acc = memreq_val && memreq_rdy;
            rcv = memresp_val && memresp_rdy;
            if (rcv) begin
                n_cmp++;
                if (memresp_msg !== expq[got] || memresp_err !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_resp_%0d: got %h required %h", got, memresp_msg, expq[got]);
                end
            end
            @(posedge clk); #1;
            if (acc) begin sent++; outst++; end
            if (rcv) begin got++; outst--; end
            cyc++;
        end
        memreq_val = 1'b0; memresp_rdy = 1'b1;
        n_cmp++;
        if (got != 8) begin n_fail++; $display("FAIL b2b_count: got %0d required 8", got); end
    endtask

    task automatic test_cfg_same();
        do_cfg(2'd0, 1'b0);
        n_cmp++;
        if (memreq_rdy !== 1'b1 || cfg_rdy !== 1'b1) begin
            n_fail++; $display("FAIL cfg_same_owner: memreq_rdy=%b cfg_rdy=%b required 1 1", memreq_rdy, cfg_rdy);
        end
    endtask

`ifdef PLAB5_MCORE_PART_MEM_SCRUB_EN
    task automatic test_scrub();
        logic [44:0] em, rm; logic ee, rd, re; int lat, n;
        do_cfg(2'd1, 1'b0);
        n = 0;
        while (memreq_rdy !== 1'b1 && n < 1000) begin n++; @(posedge clk); #1; end
        n_cmp++;
        if (n != 256) begin n_fail++; $display("FAIL scrub_cycles: got %0d required 256", n); end
        for (int b = 1024; b < 2048; b++) m_mem[b] = 8'h00;
        xact(0, 32'h410, 0, 32'h0, 1'b0, em, ee, rm, rd, re, lat);
        n_cmp++;
        if (rm[31:0] !== 32'h0 || re !== 1'b0) begin
            n_fail++; $display("FAIL scrub_read: data=%h err=%b required 0 0", rm[31:0], re);
        end
        do_cfg(2'd1, 1'b1);
        repeat (10) @(posedge clk);
        #1; reset = 1'b1;
        repeat (2) @(posedge clk);
        #1; reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
        n_cmp++;
        if (memreq_rdy !== 1'b1 || cfg_rdy !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_scrub: memreq_rdy=%b cfg_rdy=%b required 1 1", memreq_rdy, cfg_rdy);
        end
        xact(0, 32'h410, 0, 32'h0, 1'b1, em, ee, rm, rd, re, lat);
        n_cmp++;
        if (re !== 1'b0) begin n_fail++; $display("FAIL owner_after_reset: err=%b required 0", re); end
    endtask
`else
    task automatic test_cfg();
        logic [44:0] em, rm; logic ee, rd, re; int lat;
        do_cfg(2'd1, 1'b0);
        n_cmp++;
        if (memreq_rdy !== 1'b1) begin n_fail++; $display("FAIL cfg_no_stall: memreq_rdy=%b required 1", memreq_rdy); end
        xact(0, 32'h410, 0, 32'h0, 1'b0, em, ee, rm, rd, re, lat);
        n_cmp++;
        if (rm !== em || re !== 1'b0) begin
            n_fail++; $display("FAIL cfg_new_owner: msg=%h err=%b required %h 0", rm, re, em);
        end
        xact(0, 32'h414, 0, 32'h0, 1'b1, em, ee, rm, rd, re, lat);
        n_cmp++;
        if (re !== 1'b1) begin n_fail++; $display("FAIL cfg_old_owner: err=%b required 1", re); end
        do_cfg(2'd1, 1'b1);
    endtask
`endif

    initial begin
        test_reset();
        test_init();
        test_directed();
        test_random();
        test_back_to_back();
        test_cfg_same();
`ifdef PLAB5_MCORE_PART_MEM_SCRUB_EN
        test_scrub();
`else
        test_cfg();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
